// File: rtl/clock_time_controller.sv
// Digital-clock sequencer: 1 Hz prescaler, s/m/h cascade, set-mode FSM, 12/24 h mapping.
// Define CLOCK_TIME_CONTROLLER_BLINK_EN to build the set-field blink generator.
module clock_time_controller #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned DIV_BITS = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       switch_format,
    output logic       tick,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       pm,
    output logic [1:0] state,
    output logic       blink
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHour = 2'b01,
        StSetMin  = 2'b10
    } state_e;

    localparam logic [DIV_BITS-1:0] TickLast = DIV_BITS'(TICK_DIV - 1);

    state_e              state_q, state_d;
    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [5:0]          sec_q, sec_d;
    logic [5:0]          min_q, min_d;
    logic [4:0]          h24_q, h24_d;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        sec_d   = sec_q;
        min_d   = min_q;
        h24_d   = h24_q;
        case (state_q)
            StRun: begin
                // A mode press wins over a coincident tick.
                if (mode_btn) begin
                    state_d = StSetHour;
                    presc_d = '0;
                end else if (presc_q == TickLast) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = 6'd0;
                        if (min_q == 6'd59) begin
                            min_d = 6'd0;
                            h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StSetHour: begin
                presc_d = '0;
                if (mode_btn) begin
                    state_d = StSetMin;
                end else if (inc_btn) begin
                    h24_d = (h24_q == 5'd23) ? 5'd0 : h24_q + 5'd1;
                end
            end
            StSetMin: begin
                presc_d = '0;
                if (mode_btn) begin
                    state_d = StRun;
                    sec_d   = 6'd0;
                end else if (inc_btn) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                state_d = StRun;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StRun;
            presc_q <= '0;
            tick_q  <= 1'b0;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            h24_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            h24_q   <= h24_d;
        end
    end

    always_comb begin
        hours = h24_q;
        if (switch_format) begin
            if (h24_q == 5'd0) begin
                hours = 5'd12;
            end else if (h24_q > 5'd12) begin
                hours = h24_q - 5'd12;
            end
        end
    end

    assign pm      = (h24_q >= 5'd12);
    assign tick    = tick_q;
    assign seconds = sec_q;
    assign minutes = min_q;
    assign state   = state_q;

`ifdef CLOCK_TIME_CONTROLLER_BLINK_EN
    localparam logic [DIV_BITS-1:0] HalfLast = DIV_BITS'(TICK_DIV / 2 - 1);

    logic [DIV_BITS-1:0] half_q, half_d;
    logic                blink_q, blink_d;

    // Any mode press restarts the blink phase, so each set state starts dark.
    always_comb begin
        half_d  = '0;
        blink_d = 1'b0;
        if (state_q != StRun && !mode_btn) begin
            if (half_q == HalfLast) begin
                half_d  = '0;
                blink_d = ~blink_q;
            end else begin
                half_d  = half_q + 1'b1;
                blink_d = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            half_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            half_q  <= half_d;
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Sequencing controller for the digital-clock datapath.
- Generates the 1 Hz tick from the system clock and cascades seconds into minutes into hours.
- Provides a button-driven set-mode FSM for hours and minutes.
- Maps the internal 24 h hour count to 12 h or 24 h display format, as selected by switch_format.
- Sits between the button debouncers and the 7-segment display decoders.

Parameters:
- TICK_DIV, 50000000, system clock cycles per 1 s tick; must be ≥2 and even.
- DIV_BITS, 26, width of the prescaler counter; must satisfy 2^DIV_BITS ≥ TICK_DIV.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- mode_btn  input  1  one-cycle pulse (debounced upstream); advances the mode FSM.
- inc_btn  input  1  one-cycle pulse; increments the field selected in a set state.
- switch_format  input  1  0 = 24 h display, 1 = 12 h display.
- tick  output  1  one-cycle pulse each elapsed second (RUN state only).
- seconds  output  6  0..59.
- minutes  output  6  0..59.
- hours  output  5  display hour: 0..23 in 24 h mode, 1..12 in 12 h mode.
- pm  output  1  1 when internal hour ≥ 12, in both formats.
- state  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN.
- blink  output  1  set-field blink indicator (see Optional Feature).

Behaviour:
- Reset (reset=0 at a clk edge):
  - state = RUN; prescaler, seconds, minutes and internal hour h24 = 0; tick = 0; blink = 0.
  - Display outputs after reset: hours = 0, pm = 0 in 24 h mode; hours = 12, pm = 0 in 12 h mode.
- Reset has priority over every other input and takes effect mid-operation in any state.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick is registered: it is 1 for the single cycle after the prescaler has been at TICK_DIV-1; the prescaler wraps to 0 on that same edge.
  - Held at 0 in SET_HOUR and SET_MIN.
- Cascade on tick:
  - seconds increments; 59 → 0 with a carry into minutes.
  - minutes 59 → 0 with a carry into h24.
  - h24 23 → 0.
  - All counter updates land in the same cycle tick is asserted.
- FSM transitions:
  - mode_btn pulses advance RUN → SET_HOUR → SET_MIN → RUN.
  - Entering SET_HOUR: prescaler cleared; seconds held at their current value.
  - Leaving SET_MIN for RUN: seconds = 0 and prescaler = 0, so the first tick arrives exactly TICK_DIV cycles later.
- inc_btn:
  - In SET_HOUR: h24 increments, 23 → 0.
  - In SET_MIN: minutes increment, 59 → 0, with no carry into hours.
  - In RUN: ignored.
- mode_btn and inc_btn in the same cycle: the mode transition is taken and inc is ignored.
- Format mapping (combinational from h24 and switch_format):
  - 12 h mode: h24 = 0 → 12; 1..11 → unchanged; 12 → 12; 13..23 → h24 - 12.
  - 24 h mode: hours = h24.
- Toggling switch_format changes only the display mapping. It never alters the stored counts and never produces a tick.

Optional Feature:
- Macro: CLOCK_TIME_CONTROLLER_BLINK_EN.
- Defined:
  - A half-period counter runs in SET_HOUR and SET_MIN and toggles blink every TICK_DIV/2 cycles.
  - blink = 0 on entering a set state.
  - blink is forced to 0 in RUN and on reset.
- Undefined: blink is tied to constant 0 and no counter is synthesized.

Test Plan (TICK_DIV=4, DIV_BITS=3):
- Reset held low 3 cycles, switch_format=1 → state=00, seconds=0, minutes=0, hours=12, pm=0, tick=0; release reset → first tick 4 cycles later, seconds=1.
- Preload via set mode to 23:59, return to RUN, wait 60 ticks → on the 60th tick seconds=0, minutes=0, hours=0 (24 h); with switch_format=1, hours=12, pm=0.
- mode_btn once, inc_btn 13 times from h24=0 → state=01, hours=13 (24 h), then switch_format=1 → hours=1, pm=1; inc_btn 11 more times → h24 wraps to 0.
- In SET_MIN with minutes=59 and h24=5, inc_btn → minutes=0, hours stays 5; mode_btn → state=00, seconds=0, tick exactly 4 cycles later.
- mode_btn and inc_btn together in RUN → state=01, h24 unchanged; reset asserted while in SET_MIN → state=00, all counts 0 on the next edge.
- With CLOCK_TIME_CONTROLLER_BLINK_EN defined, in SET_HOUR → blink toggles every 2 cycles; on return to RUN → blink=0. Without the macro → blink=0 throughout.
